// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-side definitions (widths, NOP encoding,
// reset PC default, buffer entry layout) for the fetch unit and its buffer.
package fetch_unit_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int              BUF_DEPTH        = 2;

    // One decoded-side slot: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Sequential next PC; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry in-order FIFO of {pc, inst} sitting between the
// instruction memory response path and decode. Flush empties it in one cycle;
// a push and a pop in the same cycle both take effect.
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t w_slots [BUF_DEPTH];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    // A pop needs an entry; a push needs a free slot or a simultaneous pop.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            fetch_entry_t r_entry;

            // Capture the pushed entry into the slot named by the write pointer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_entry <= i_data;
                end
            end

            assign w_slots[gi] = r_entry;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head  = w_slots[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a 2-entry decode buffer,
// request throttling (inflight + buffered <= 2) and branch redirect that
// drops responses still in flight from the old path.
// Optional feature macro: FETCH_MISALIGN_CHK_EN adds misalign_o and halts
// fetching after a redirect to a non-word-aligned target; without it the
// low two address bits are forced to zero.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_data_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            inst_valid_o,
    input  logic            id_ready_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_o
`endif
);

    logic [XLEN-1:0] r_fetch_pc;   // address of the next request
    logic [XLEN-1:0] r_resp_pc;    // PC belonging to the next kept response
    logic [1:0]      r_inflight;   // accepted requests not yet answered
    logic [1:0]      r_drop;       // stale responses still to be discarded
    logic [1:0]      w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_stop;
    logic            w_req_fire;
    logic            w_rsp;
    logic            w_keep;
    logic            w_pop;
    logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;

    assign w_target   = branch_target_i;
    assign w_stop     = r_misalign;
    assign misalign_o = r_misalign;
    assign req_addr_o = r_fetch_pc;

    // A redirect to a misaligned target stops fetching until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (branch_i && (branch_target_i[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end
`else
    logic w_unused;

    // Targets are word-aligned on entry so pc_o matches the address fetched.
    assign w_target   = {branch_target_i[XLEN-1:2], 2'b00};
    assign w_stop     = 1'b0;
    assign req_addr_o = {r_fetch_pc[XLEN-1:2], 2'b00};
    assign w_unused   = ^{branch_target_i[1:0], r_fetch_pc[1:0]};
`endif

    assign inst_valid_o = (w_count != 2'd0);
    assign pc_o         = inst_valid_o ? w_head.pc : '0;
    assign inst_o       = inst_valid_o ? w_head.inst : NOP_INST;

    // Only request when every possible response already has a buffer slot.
    assign req_valid_o = rst_n && !branch_i && !w_stop &&
                         (({1'b0, r_inflight} + {1'b0, w_count}) < 3'd2);
    assign w_req_fire  = req_valid_o && req_ready_i;

    // A response with nothing outstanding is not ours (e.g. pre-reset traffic).
    assign w_rsp       = rsp_valid_i && (r_inflight != 2'd0);
    assign w_keep      = w_rsp && (r_drop == 2'd0) && !branch_i;
    assign w_pop       = inst_valid_o && id_ready_i;
    assign w_push_data = {r_resp_pc, rsp_data_i};

    fetch_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (branch_i),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Fetch/response PCs, outstanding-request count and stale-drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= 2'd0;
            r_drop     <= 2'd0;
        end else begin
            r_inflight <= r_inflight + {1'b0, w_req_fire} - {1'b0, w_rsp};
            if (branch_i) begin
                // Everything outstanding belongs to the old path; a response
                // arriving right now is already being discarded.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop     <= r_inflight - {1'b0, w_rsp};
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= next_pc(r_fetch_pc);
                end
                if (w_keep) begin
                    r_resp_pc <= next_pc(r_resp_pc);
                end
                if (w_rsp && (r_drop != 2'd0)) begin
                    r_drop <= r_drop - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit. The bench plays instruction memory
// (in-order, fixed latency) and keeps a queue-level reference model: a list
// of outstanding requests tagged live/stale and a list of buffered entries.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_o;
    logic        a_mis;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_o     (req_valid_o),
        .req_ready_i     (req_ready_i),
        .req_addr_o      (req_addr_o),
        .rsp_valid_i     (rsp_valid_i),
        .rsp_data_i      (rsp_data_i),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .inst_valid_o    (inst_valid_o),
        .id_ready_i      (id_ready_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_o      (misalign_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        bit          rdy;
        bit          idr;
        bit          br;
        logic [31:0] tgt;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] pc;
    } vec_t;

    req_t        mq[$];     // outstanding requests, oldest first
    ent_t        mbuf[$];   // what decode should see, head first
    logic [31:0] m_pc;
    bit          m_mis;
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_fail;

    logic        a_rv;
    logic [31:0] a_addr;
    logic        a_iv;
    logic [31:0] a_pc;
    logic [31:0] a_inst;

    vec_t        tbl[10];

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mkv(input bit rdy, input bit idr, input bit br, input logic [31:0] tgt,
                                 input bit rv, input logic [31:0] addr, input bit iv, input logic [31:0] pc);
        vec_t v;
        v.rdy = rdy; v.idr = idr; v.br = br; v.tgt = tgt;
        v.rv = rv; v.addr = addr; v.iv = iv; v.pc = pc;
        return v;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, play memory, compare against the model,
    // then advance the model to what the rising edge should produce.
    task automatic step(input bit rdy, input bit idr, input bit br, input logic [31:0] tgt);
        bit          e_rv;
        bit          e_iv;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        bit          kept;
        bit          popped;
        req_t        r;
        @(negedge clk);
        req_ready_i     = rdy;
        id_ready_i      = idr;
        branch_i        = br;
        branch_target_i = tgt;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_valid_i = 1'b1;
            rsp_data_i  = mem_data(mq[0].addr);
        end else begin
            rsp_valid_i = 1'b0;
            rsp_data_i  = $urandom;
        end
        #1;
        e_rv = !br && !m_mis && ((mq.size() + mbuf.size()) < 2);
`ifdef FETCH_MISALIGN_CHK_EN
        e_addr = m_pc;
`else
        e_addr = {m_pc[31:2], 2'b00};
`endif
        e_iv   = (mbuf.size() > 0);
        e_pc   = e_iv ? mbuf[0].pc : 32'h0;
        e_inst = e_iv ? mbuf[0].inst : NOP_INST;
        a_rv = req_valid_o; a_addr = req_addr_o; a_iv = inst_valid_o; a_pc = pc_o; a_inst = inst_o;
        chk("req_valid_o", a_rv, e_rv);
        chk("req_addr_o", a_addr, e_addr);
        chk("inst_valid_o", a_iv, e_iv);
        chk("pc_o", a_pc, e_pc);
        chk("inst_o", a_inst, e_inst);
`ifdef FETCH_MISALIGN_CHK_EN
        a_mis = misalign_o;
        chk("misalign_o", a_mis, m_mis);
`endif
        popped = e_iv && idr;
        kept   = 1'b0;
        if (rsp_valid_i) begin
            r    = mq.pop_front();
            kept = r.live && !br;
        end
        if (popped) begin
            $display("cycle %0d: decode takes pc=0x%08h inst=0x%08h", cyc, mbuf[0].pc, mbuf[0].inst);
        end
        if (br) begin
            foreach (mq[i]) mq[i].live = 1'b0;
            mbuf.delete();
`ifdef FETCH_MISALIGN_CHK_EN
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            m_pc = tgt;
`else
            m_pc = {tgt[31:2], 2'b00};
`endif
        end else begin
            if (popped) void'(mbuf.pop_front());
            if (kept) mbuf.push_back('{r.addr, mem_data(r.addr)});
        end
        if (e_rv && rdy) begin
            mq.push_back('{e_addr, cyc + lat, 1'b1});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    // Asynchronous reset away from the clock edge; memory is reset with it.
    task automatic do_reset(input int new_lat);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_ready_i = 1'b0; id_ready_i = 1'b0; branch_i = 1'b0;
        branch_target_i = 32'h0; rsp_valid_i = 1'b0; rsp_data_i = 32'h0;
        #1;
        chk("rst_req_valid", req_valid_o, 32'h0);
        chk("rst_inst_valid", inst_valid_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, NOP_INST);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", misalign_o, 32'h0);
`endif
        mq.delete();
        mbuf.delete();
        m_pc  = 32'h0;
        m_mis = 1'b0;
        lat   = new_lat;
        cyc   = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Run with decode ready until an entry shows up, then check its PC.
    task automatic wait_iv(input string name, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (a_iv) begin
                seen = 1'b1;
                chk(name, a_pc, exp_pc);
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no inst_valid_o within 20 cycles, expected pc 0x%08h", name, exp_pc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        m_mis    = 1'b0;
        cyc      = 0;

        // Directed table: 1-cycle memory, straight-line fetch then a redirect.
        tbl[0] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000);
        tbl[1] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000);
        tbl[2] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000);
        tbl[3] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004);
        tbl[4] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b0, 32'h000);
        tbl[5] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        tbl[6] = mkv(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h010, 1'b1, 32'h00C);
        tbl[7] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000);
        tbl[8] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000);
        tbl[9] = mkv(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h100);

        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rdy, tbl[i].idr, tbl[i].br, tbl[i].tgt);
            $display("vector %0d: req_valid=%0b addr=0x%08h inst_valid=%0b pc=0x%08h", i, a_rv, a_addr, a_iv, a_pc);
            chk("tbl_req_valid", a_rv, tbl[i].rv);
            chk("tbl_req_addr", a_addr, tbl[i].addr);
            chk("tbl_inst_valid", a_iv, tbl[i].iv);
            chk("tbl_pc", a_pc, tbl[i].pc);
            chk("tbl_inst", a_inst, tbl[i].iv ? mem_data(tbl[i].pc) : NOP_INST);
        end

        // Decode stall for 5 cycles: buffer fills to 2, requests stop, head holds.
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (k >= 2) begin
                chk("stall_req_valid", a_rv, 32'h0);
                chk("stall_pc", a_pc, 32'h0);
                chk("stall_inst", a_inst, mem_data(32'h0));
            end
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("resume_pc0", a_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("resume_pc4", a_pc, 32'h4);
        wait_iv("resume_pc8", 32'h8);

        // Redirect with two stale requests outstanding (3-cycle memory).
        do_reset(3);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h100);
        chk("branch_blocks_req", a_rv, 32'h0);
        wait_iv("stale_drop_pc", 32'h100);

        // Redirect in the same cycle the only outstanding response returns.
        do_reset(1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("same_cycle_req_valid", a_rv, 32'h1);
        chk("same_cycle_req_addr", a_addr, 32'h100);
        wait_iv("same_cycle_pc", 32'h100);

        // Fetch PC wraps past the top of the address space.
        do_reset(2);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        wait_iv("wrap_pc_a", 32'hFFFF_FFF8);
        wait_iv("wrap_pc_b", 32'hFFFF_FFFC);
        wait_iv("wrap_pc_c", 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHK_EN
        // Misaligned redirect: flag set, fetching halts until reset.
        do_reset(1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h102);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("misalign_flag", a_mis, 32'h1);
            chk("misalign_req_valid", a_rv, 32'h0);
            chk("misalign_inst_valid", a_iv, 32'h0);
        end
        do_reset(1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("misalign_cleared", a_mis, 32'h0);
        chk("misalign_restart", a_rv, 32'h1);
`else
        // Misaligned target is word-aligned before fetching.
        do_reset(1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h102);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("align_req_addr", a_addr, 32'h100);
        wait_iv("align_pc", 32'h100);
`endif

        // Randomised traffic; segment 3 toggles req_ready_i with 3-cycle memory,
        // segment 2 takes an asynchronous reset in the middle of traffic.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset((seg == 3) ? 3 : 1 + seg);
            for (int k = 0; k < 400; k++) begin
                bit rdy;
                bit idr;
                bit br;
                if (seg == 2 && k == 200) do_reset(3);
                rdy = (seg == 3) ? k[0] : ($urandom_range(0, 3) != 0);
                idr = ($urandom_range(0, 3) != 0);
                br  = ($urandom_range(0, 15) == 0);
                step(rdy, idr, br, rand_tgt());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have ports clk (input, 1): single clock; all state on rising edge.
REQ-003 SHALL have rst_n (input, 1): reset, asynchronous, active-low.
REQ-004 SHALL have imem request ports: req_valid_o (output, 1) request valid; req_ready_i (input, 1) memory accepts; req_addr_o (output, 32) word address.
REQ-005 SHALL have imem response ports: rsp_valid_i (input, 1) data valid; rsp_data_i (input, 32) instruction; responses in request order, at least 1 cycle after acceptance.
REQ-006 SHALL have decode-side ports: inst_o (output, 32) instruction; pc_o (output, 32) its PC; inst_valid_o (output, 1) entry valid; id_ready_i (input, 1) decode consumes head.
REQ-007 SHALL have redirect ports: branch_i (input, 1) taken branch or jump; branch_target_i (input, 32) new PC.

Function
REQ-008 SHALL hold a 2-entry in-order buffer of {pc, inst}; head drives pc_o/inst_o; inst_valid_o = buffer non-empty.
REQ-009 SHALL drive inst_o = 32'h0000_0013 (addi x0,x0,0) and pc_o = 0 when buffer empty.
REQ-010 SHALL pop head when inst_valid_o && id_ready_i; buffer contents SHALL hold while id_ready_i=0 (stall).
REQ-011 SHALL assert req_valid_o iff !branch_i && inflight + occupancy < 2; req_addr_o = fetch PC.
REQ-012 SHALL, on req_valid_o && req_ready_i, increment fetch PC by 4 (wrap at 2^32) and inflight by 1.
REQ-013 SHALL track resp_pc = PC of next expected response; a kept response pushes {resp_pc, rsp_data_i} and advances resp_pc by 4.
REQ-014 SHALL decrement inflight on every rsp_valid_i; push and pop in the same cycle SHALL both take effect.
REQ-015 SHALL, on branch_i, in that cycle: pop head if id_ready_i; flush all other entries; set fetch PC and resp_pc to branch_target_i; set drop count = inflight minus 1 if rsp_valid_i that cycle, else inflight.
REQ-016 SHALL discard responses while drop count > 0, decrementing it; discarded data never reaches the buffer.
REQ-017 SHALL treat branch_i on consecutive cycles as independent redirects; latest target wins, drop count recomputed each time.
REQ-018 SHALL give a redirect-to-first-valid latency of 2 cycles with no stale inflight and 1-cycle memory.
REQ-019 SHALL never overflow: kept responses always find a free slot by construction of REQ-011.

Reset
REQ-020 SHALL, while rst_n=0, clear buffer, inflight and drop count, set fetch PC and resp_pc to RESET_PC, hold req_valid_o=0 and misalign_o=0.
REQ-021 SHALL issue first request to RESET_PC in first cycle after rst_n deasserts; reset mid-operation discards all state, late responses ignored (drop count cleared, inflight 0).

Configuration
REQ-022 SHALL, with FETCH_MISALIGN_CHK_EN defined, add output misalign_o (1): on branch_i with branch_target_i[1:0]!=0, set misalign_o=1, flush, stop requests until reset.
REQ-023 SHALL, without FETCH_MISALIGN_CHK_EN, omit misalign_o and force req_addr_o[1:0]=2'b00.

Structure
REQ-024 SHALL take NOP encoding, instruction/address widths and RESET_PC default from the shared buceros header.
REQ-025 SHALL implement the buffer as sub-module fetch_buf (2-entry FIFO, push/pop/flush, count output).

Verification
REQ-026 Reset release, req_ready_i=1, 1-cycle memory -> requests 0x0,0x4,0x8...; first inst_valid_o at cycle 2 with pc_o=0x0.
REQ-027 id_ready_i=0 for 5 cycles -> buffer full at 2, req_valid_o=0, pc_o/inst_o unchanged; release -> in-order resume, no loss.
REQ-028 branch_i, target 0x100, 2 inflight -> both stale responses dropped; next inst_valid_o has pc_o=0x100.
REQ-029 branch_i with rsp_valid_i same cycle, 1 inflight -> response dropped, drop count 0, next fetch 0x100.
REQ-030 req_ready_i toggled 1/0 with 3-cycle memory latency -> sequential PCs, never more than 2 inflight+buffered.
REQ-031 With FETCH_MISALIGN_CHK_EN: target 0x102 -> misalign_o=1, req_valid_o=0, inst_valid_o=0 until rst_n.
